// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding,
// scancode prefix constants and the frame acceptance check.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Prefix bytes: E0 marks an extended key, F0 marks a key release.
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Queue entry layout: {code[7:0], release, extended}.
    localparam int ENTRY_W = 10;

    // A frame is good when the stop bit is 1 and data+parity hold an odd
    // number of ones (PS/2 uses odd parity).
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       par,
                                      input logic       stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO for decoded keys.
// Handshake: the head entry is on rd_data whenever rd_valid is 1; it is
// consumed in any cycle where rd_valid && rd_ready, and the next entry
// appears on rd_data the following cycle. A push into a full FIFO is
// accepted only if a pop happens in the same cycle; otherwise the new
// entry is dropped and overflow pulses for that cycle.
module ps2_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // The extra pointer MSB tells full (MSBs differ) from empty (equal).
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = !empty && rd_ready;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    assign rd_valid = !empty;
    // Head fields read as zero while nothing is queued.
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because rd_data is gated.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the keyboard clock,
// deserialises 11-bit frames, folds E0/F0 prefixes into flags and queues
// decoded keys. Output handshake: key_* fields are valid while key_valid
// is 1; the head is consumed on key_valid && key_ready.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_extended,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic [1:0] dbg_state
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2;
    logic          din_s1, din_s2;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          filt_clk_d;
    logic          sample;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          byte_done;
    logic          byte_bad;

    logic          done_q;
    logic [7:0]    done_code;
    logic          is_ext;
    logic          is_brk;
    logic          push;
    logic          rel_q;
    logic          ext_q;

    logic [ENTRY_W-1:0] head;

    // Two-flop synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            din_s1 <= 1'b1;
            din_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            din_s1 <= ps2_din;
            din_s2 <= din_s1;
        end
    end

    // Glitch filter: follow the synchronised clock only after FILTER_LEN
    // consecutive samples disagreeing with the current filtered value.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // One-cycle sample strobe on each falling edge of the filtered clock.
    assign sample  = filt_clk_d && !filt_clk;
    assign tmo_hit = (state_q != ST_IDLE) && !sample &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Receive FSM state register.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Receive FSM next state plus byte-complete / byte-bad strobes.
    always_comb begin
        state_d   = state_q;
        byte_done = 1'b0;
        byte_bad  = 1'b0;
        if (tmo_hit) begin
            state_d  = ST_IDLE;
            byte_bad = 1'b1;
        end else if (sample) begin
            case (state_q)
                ST_IDLE:   if (!din_s2) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (frame_ok(shift_q, par_q, din_s2)) byte_done = 1'b1;
                    else                                  byte_bad  = 1'b1;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Shift register, bit counter and parity capture on sample events.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: bit_cnt <= '0;
                ST_DATA: begin
                    shift_q <= {din_s2, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_PARITY: par_q <= din_s2;
                default: ;
            endcase
        end
    end

    // Inter-edge timeout counter; idle and every sample event restart it.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n)                            tmo_cnt <= '0;
        else if (state_q == ST_IDLE || sample) tmo_cnt <= '0;
        else                                   tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Register the frame outcome; push and error pulse follow one cycle later.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            done_code <= '0;
            frame_err <= 1'b0;
        end else begin
            done_q    <= byte_done;
            frame_err <= byte_bad;
            if (byte_done) done_code <= shift_q;
        end
    end

    assign is_ext = done_q && (done_code == CODE_EXT);
    assign is_brk = done_q && (done_code == CODE_BRK);
    assign push   = done_q && !is_ext && !is_brk;

    // Prefix flags: set by E0/F0, cleared after a push or any frame error.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rel_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (frame_err || push) begin
            rel_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (is_ext) begin
            ext_q <= 1'b1;
        end else if (is_brk) begin
            rel_q <= 1'b1;
        end
    end

    ps2_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk25),
        .rst_n    (rst_n),
        .push     (push),
        .wr_data  ({done_code, rel_q, ext_q}),
        .rd_ready (key_ready),
        .rd_valid (key_valid),
        .rd_data  (head),
        .overflow (overflow)
    );

    assign key_code     = head[9:2];
    assign key_release  = head[1];
    assign key_extended = head[0];
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a table of frame sequences with
// hand-computed decoded entries, plus hand-written latency, timeout,
// reset, glitch and overflow sequences.
module tb_ps2_keyboard_rx;
    localparam int HALF = 30;   // clk25 cycles per PS/2 clock half-period

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_din = 1'b1;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       key_valid;
    logic       frame_err;
    logic       overflow;
    logic [1:0] dbg_state;

    ps2_keyboard_rx dut (
        .clk25        (clk25),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_din      (ps2_din),
        .key_code     (key_code),
        .key_release  (key_release),
        .key_extended (key_extended),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter.
    always #20 clk25 = ~clk25;
    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // Monitor: records popped entries, error/overflow pulses, valid timing.
    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int obs_rd = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int rise_cyc = -1;
    int valid_run = 0;
    int last_run = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk25) begin
        if (key_valid && key_ready) obs_q.push_back({key_code, key_release, key_extended});
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
        if (key_valid && !prev_valid) rise_cyc = cyc;
        if (key_valid) valid_run++;
        else if (prev_valid) begin
            last_run = valid_run;
            valid_run = 0;
        end
        prev_valid = key_valid;
    end

    int total = 0;
    int bad = 0;
    int stop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare everything popped since the last call against exp_q.
    task automatic score(input string name);
        check({name, " count"}, obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            check({name, " entry"}, obs_q[obs_rd], exp_q.pop_front());
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then clock low, then high.
    task automatic ps2_bit(input logic b, input bit is_stop, input bit glitch);
        ps2_din = b;
        if (glitch) begin
            tick(10);
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(HALF - 11);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic par;
        par = ~^b;
        if (bad_par) par = ~par;
        ps2_bit(1'b0, 1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, glitch);
        ps2_bit(par, 1'b0, glitch);
        ps2_bit(!bad_stop, 1'b1, glitch);
        ps2_din = 1'b1;
        tick(40);
    endtask

    typedef struct {
        logic [23:0] bytes;     // byte i at [8*i +: 8], sent in order
        int          n;
        logic [2:0]  bad_par;
        logic [2:0]  bad_stop;
        int          exp_n;
        logic [9:0]  exp_entry; // {code, release, extended}
        int          exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int base_err;
        int base_ovf;

        vecs[0] = '{bytes: 24'h00001C, n: 1, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h1C, 1'b0, 1'b0}, exp_err: 0};
        vecs[1] = '{bytes: 24'h001CF0, n: 2, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h1C, 1'b1, 1'b0}, exp_err: 0};
        vecs[2] = '{bytes: 24'h00001C, n: 1, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h1C, 1'b0, 1'b0}, exp_err: 0};
        vecs[3] = '{bytes: 24'h75F0E0, n: 3, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h75, 1'b1, 1'b1}, exp_err: 0};
        vecs[4] = '{bytes: 24'h00001C, n: 1, bad_par: 3'b001, bad_stop: 3'b000, exp_n: 0, exp_entry: 10'h000, exp_err: 1};
        vecs[5] = '{bytes: 24'h00001C, n: 1, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h1C, 1'b0, 1'b0}, exp_err: 0};
        vecs[6] = '{bytes: 24'h005AE0, n: 2, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h5A, 1'b0, 1'b1}, exp_err: 0};
        vecs[7] = '{bytes: 24'h29F0E0, n: 3, bad_par: 3'b010, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h29, 1'b0, 1'b0}, exp_err: 1};
        vecs[8] = '{bytes: 24'h331CF0, n: 3, bad_par: 3'b000, bad_stop: 3'b010, exp_n: 1, exp_entry: {8'h33, 1'b0, 1'b0}, exp_err: 1};
        vecs[9] = '{bytes: 24'h0012E0, n: 2, bad_par: 3'b000, bad_stop: 3'b000, exp_n: 1, exp_entry: {8'h12, 1'b0, 1'b1}, exp_err: 0};

        // Reset state.
        tick(4);
        check("rst key_valid", key_valid, 1'b0);
        check("rst key_code", key_code, 8'h00);
        check("rst key_release", key_release, 1'b0);
        check("rst key_extended", key_extended, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst overflow", overflow, 1'b0);
        check("rst state", dbg_state, 2'd0);
        rst_n = 1'b1;
        tick(10);

        // Latency: key_valid rises 12 cycles after the stop-bit fall is
        // driven (2 sync + 8 filter + 1 outcome register + 1 FIFO write),
        // and with key_ready=1 it stays high for exactly one cycle.
        rise_cyc = -1;
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("latency", rise_cyc - stop_cyc, 12);
        check("valid width", last_run, 1);
        score("first 1C");

        // Table-driven frame sequences.
        for (int v = 0; v < 10; v++) begin
            base_err = err_cnt;
            if (vecs[v].exp_n == 1) exp_q.push_back(vecs[v].exp_entry);
            for (int k = 0; k < vecs[v].n; k++)
                send_frame(vecs[v].bytes[8*k +: 8], vecs[v].bad_par[k], vecs[v].bad_stop[k], 1'b0);
            tick(5);
            check($sformatf("vec%0d errors", v), err_cnt - base_err, vecs[v].exp_err);
            score($sformatf("vec%0d", v));
        end

        // Timeout: start bit plus 4 data bits, then silence.
        base_err = err_cnt;
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0, 1'b0);
        check("timeout pending state", dbg_state, 2'd1);
        tick(5200);
        check("timeout err", err_cnt - base_err, 1);
        check("timeout state", dbg_state, 2'd0);
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        score("after timeout");

        // Reset mid-frame discards the partial frame.
        base_err = err_cnt;
        ps2_bit(1'b0, 1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0, 1'b0);
        check("midframe state", dbg_state, 2'd1);
        rst_n = 1'b0;
        tick(2);
        check("midreset state", dbg_state, 2'd0);
        check("midreset valid", key_valid, 1'b0);
        rst_n = 1'b1;
        tick(20);
        exp_q.push_back({8'h4B, 1'b0, 1'b0});
        send_frame(8'h4B, 1'b0, 1'b0, 1'b0);
        check("after reset err", err_cnt - base_err, 0);
        score("after reset");

        // One-cycle clock glitches while idle and inside a frame.
        base_err = err_cnt;
        repeat (5) begin
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(20);
        end
        check("idle glitch state", dbg_state, 2'd0);
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("glitch err", err_cnt - base_err, 0);
        score("glitch frame");

        // Overflow: 9 frames with no consumer, then drain.
        key_ready = 1'b0;
        base_ovf = ovf_cnt;
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
        check("ovf before 9th", ovf_cnt - base_ovf, 0);
        send_frame(8'h09, 1'b0, 1'b0, 1'b0);
        check("ovf on 9th", ovf_cnt - base_ovf, 1);
        check("full head valid", key_valid, 1'b1);
        check("full head code", key_code, 8'h01);
        for (int k = 1; k <= 8; k++) exp_q.push_back({8'(k), 1'b0, 1'b0});
        key_ready = 1'b1;
        tick(20);
        score("drain");
        check("drained valid", key_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
